// File: rtl/b16_pkg.sv
// b16_pkg: shared parameter defaults and backing-store direction constants for spill_stack
package b16_pkg;
  localparam int L_DEF = 16;
  localparam int DEP_DEF = 3;
  localparam int SPW_DEF = 8;
  localparam int HI_DEF = 6;
  localparam int LO_DEF = 1;
  localparam logic SP_SPILL = 1'b1;
  localparam logic SP_FILL = 1'b0;
endpackage

// File: rtl/stack_regs.sv
// stack_regs: N x L register file; ports: clk, top-side write (we_t/wa_t/wd_t), bottom-side write (we_b/wa_b/wd_b), async reads ra_t->rd_t, ra_b->rd_b
module stack_regs #(
  parameter int L = 16,
  parameter int DEP = 3
) (
  input  logic           clk,
  input  logic           we_t,
  input  logic [DEP-1:0] wa_t,
  input  logic [L-1:0]   wd_t,
  input  logic           we_b,
  input  logic [DEP-1:0] wa_b,
  input  logic [L-1:0]   wd_b,
  input  logic [DEP-1:0] ra_t,
  input  logic [DEP-1:0] ra_b,
  output logic [L-1:0]   rd_t,
  output logic [L-1:0]   rd_b
);
  logic [L-1:0] mem [2**DEP];
  always_ff @(posedge clk) begin
    if (we_t) mem[wa_t] <= wd_t;
    if (we_b) mem[wa_b] <= wd_b;
  end
  assign rd_t = mem[ra_t];
  assign rd_b = mem[ra_b];
endmodule

// File: rtl/spill_stack.sv
// spill_stack: on-chip ring stack with spill/fill to a backing store; ports: clk, reset, push/pop/din/clr_err in, tos/count/push_rdy/pop_rdy/ovf/unf out, sp_req/sp_we/sp_addr/sp_wdata out, sp_ack/sp_rdata in
module spill_stack import b16_pkg::*; #(
  parameter int L = L_DEF,
  parameter int DEP = DEP_DEF,
  parameter int SPW = SPW_DEF,
  parameter int HI = HI_DEF,
  parameter int LO = LO_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [L-1:0]   din,
  input  logic           clr_err,
  output logic [L-1:0]   tos,
  output logic [DEP:0]   count,
  output logic           push_rdy,
  output logic           pop_rdy,
  output logic           ovf,
  output logic           unf,
  output logic           sp_req,
  output logic           sp_we,
  output logic [SPW-1:0] sp_addr,
  output logic [L-1:0]   sp_wdata,
  input  logic           sp_ack,
  input  logic [L-1:0]   sp_rdata
);
  localparam logic [DEP:0] NC = (DEP+1)'(2**DEP);
  localparam logic [DEP:0] HIC = (DEP+1)'(HI);
  localparam logic [DEP:0] LOC = (DEP+1)'(LO);
  localparam logic [SPW:0] BMAX = {1'b1, {SPW{1'b0}}};
  logic [DEP-1:0] bot, top_i, push_i;
  logic [SPW:0] bdepth, bdm1;
  logic [L-1:0] rd_t, rd_b;
  logic fill_pend, rep, do_push, do_pop, ovf_ev, unf_ev, ack, spill_go, fill_go, spill_ack, fill_ack;
  assign fill_pend = sp_req & (sp_we == SP_FILL);
  assign push_rdy = count < NC && !(fill_pend && count == NC - 1'b1);
  assign pop_rdy = count != '0;
  assign rep = push & pop & pop_rdy;
  assign do_push = push & push_rdy & !rep;
  assign do_pop = pop & pop_rdy & !rep;
  assign ovf_ev = push & !push_rdy & !rep & count == NC & bdepth == BMAX;
  assign unf_ev = pop & !pop_rdy & bdepth == '0;
  assign ack = sp_req & sp_ack;
  assign spill_ack = ack & (sp_we == SP_SPILL);
  assign fill_ack = ack & (sp_we == SP_FILL);
  assign spill_go = !sp_req && count >= HIC && bdepth < BMAX;
  assign fill_go = !sp_req && !spill_go && count <= LOC && bdepth != '0;
  assign bdm1 = bdepth - (SPW+1)'(1);
  // bottom pointer plus count locates the top; count==N wraps to bot by truncation
  assign push_i = bot + count[DEP-1:0];
  assign top_i = push_i - DEP'(1);
  assign tos = count == '0 ? '0 : rd_t;
  stack_regs #(.L(L), .DEP(DEP)) u_regs (
    .clk  (clk),
    .we_t ((do_push | rep) & !reset),
    .wa_t (rep ? top_i : push_i),
    .wd_t (din),
    .we_b (fill_ack & !reset),
    .wa_b (bot - DEP'(1)),
    .wd_b (sp_rdata),
    .ra_t (top_i),
    .ra_b (bot),
    .rd_t (rd_t),
    .rd_b (rd_b)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      bot <= '0;
      bdepth <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      sp_req <= 1'b0;
      sp_we <= 1'b0;
      sp_addr <= '0;
      sp_wdata <= '0;
    end else begin
      count <= count + (DEP+1)'(do_push) + (DEP+1)'(fill_ack) - (DEP+1)'(do_pop) - (DEP+1)'(spill_go);
      bot <= bot + DEP'(spill_go) - DEP'(fill_ack);
      bdepth <= bdepth + (SPW+1)'(spill_ack) - (SPW+1)'(fill_ack);
      ovf <= ovf_ev | (ovf & !clr_err);
      unf <= unf_ev | (unf & !clr_err);
      if (spill_go || fill_go) begin
        sp_req <= 1'b1;
        sp_we <= spill_go ? SP_SPILL : SP_FILL;
        sp_addr <= spill_go ? bdepth[SPW-1:0] : bdm1[SPW-1:0];
        if (spill_go) sp_wdata <= rd_b;
      end else if (ack) sp_req <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spill_stack.sv
// tb_spill_stack: table-driven and directed self-checking bench for spill_stack
module tb_spill_stack;
  logic clk = 0, reset = 1, push = 0, pop = 0, clr_err = 0, sp_ack = 0;
  logic [15:0] din = 0, rdv = 0, tos, sp_wdata, sp_rdata;
  logic [3:0] count, sp_addr;
  logic push_rdy, pop_rdy, ovf, unf, sp_req, sp_we, auto_m = 0;
  logic [15:0] bmem [16];
  int checks = 0, failures = 0;
  spill_stack #(.L(16), .DEP(3), .SPW(4), .HI(6), .LO(1)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
    .tos(tos), .count(count), .push_rdy(push_rdy), .pop_rdy(pop_rdy), .ovf(ovf), .unf(unf),
    .sp_req(sp_req), .sp_we(sp_we), .sp_addr(sp_addr), .sp_wdata(sp_wdata),
    .sp_ack(sp_ack), .sp_rdata(sp_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (sp_req && sp_ack && sp_we) bmem[sp_addr] <= sp_wdata;
  assign sp_rdata = auto_m ? bmem[sp_addr] : rdv;
  typedef struct {
    logic push, pop, clr, ack;
    logic [15:0] din, rdata;
    logic [3:0] cnt;
    logic [15:0] tos;
    logic req, ovf, unf;
    logic [1:0] chk;
    logic we;
    logic [3:0] addr;
    logic [15:0] wd;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic pu, po, cl, ak, logic [15:0] d, rd, logic [3:0] c, logic [15:0] t,
                             logic rq, ov, un, logic [1:0] ck, logic we, logic [3:0] ad, logic [15:0] wd);
    vec_t r;
    r.push = pu; r.pop = po; r.clr = cl; r.ack = ak; r.din = d; r.rdata = rd; r.cnt = c; r.tos = t;
    r.req = rq; r.ovf = ov; r.unf = un; r.chk = ck; r.we = we; r.addr = ad; r.wd = wd;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int acc, e;
    logic rdy;
    tbl.push_back(v(1,0,0,0,16'h1111,0, 1,16'h1111, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h2222,0, 2,16'h2222, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h3333,0, 3,16'h3333, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h4444,0, 4,16'h4444, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h5555,0, 5,16'h5555, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h6666,0, 6,16'h6666, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,        5,16'h6666, 1,0,0, 3,1,0,16'h1111));
    tbl.push_back(v(0,0,0,0,0,0,        5,16'h6666, 1,0,0, 3,1,0,16'h1111));
    tbl.push_back(v(0,0,0,0,0,0,        5,16'h6666, 1,0,0, 3,1,0,16'h1111));
    tbl.push_back(v(0,0,0,1,0,0,        5,16'h6666, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,        5,16'h6666, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        4,16'h5555, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        3,16'h4444, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        2,16'h3333, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        1,16'h2222, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,        1,16'h2222, 1,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,0,1,0,16'h1111, 2,16'h2222, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        1,16'h1111, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        0,16'h0000, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        0,16'h0000, 0,0,1, 0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0,        0,16'h0000, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h1111,0, 1,16'h1111, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h2222,0, 2,16'h2222, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0,0,16'h3333,0, 3,16'h3333, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,1,0,0,16'hAAAA,0, 3,16'hAAAA, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        2,16'h2222, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        1,16'h1111, 0,0,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        0,16'h0000, 0,0,0, 0,0,0,0));
    tbl.push_back(v(1,1,0,0,16'h7777,0, 1,16'h7777, 0,0,1, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,        0,16'h0000, 0,0,1, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,0,        0,16'h0000, 0,0,1, 0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,0,        0,16'h0000, 0,0,0, 0,0,0,0));
    push = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0; push = 0;
    chk("rst_count", count, 0); chk("rst_tos", tos, 0); chk("rst_req", sp_req, 0);
    chk("rst_ovf", ovf, 0); chk("rst_unf", unf, 0); chk("rst_push_rdy", push_rdy, 1); chk("rst_pop_rdy", pop_rdy, 0);
    foreach (tbl[i]) begin
      push = tbl[i].push; pop = tbl[i].pop; clr_err = tbl[i].clr; sp_ack = tbl[i].ack;
      din = tbl[i].din; rdv = tbl[i].rdata;
      step();
      chk($sformatf("r%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("r%0d_tos", i), tos, tbl[i].tos);
      chk($sformatf("r%0d_req", i), sp_req, tbl[i].req);
      chk($sformatf("r%0d_ovf", i), ovf, tbl[i].ovf);
      chk($sformatf("r%0d_unf", i), unf, tbl[i].unf);
      if (tbl[i].chk[0]) begin
        chk($sformatf("r%0d_we", i), sp_we, tbl[i].we);
        chk($sformatf("r%0d_addr", i), sp_addr, tbl[i].addr);
      end
      if (tbl[i].chk[1]) chk($sformatf("r%0d_wdata", i), sp_wdata, tbl[i].wd);
    end
    push = 0; pop = 0; clr_err = 0; sp_ack = 0;
    // fill backing store to 16 words and on-chip to 8 with an auto-acking responder
    reset = 1; step(); reset = 0;
    auto_m = 1; sp_ack = 1; acc = 0;
    for (int c = 0; c < 400 && acc < 24; c++) begin
      push = 1; din = 16'h0100 + 16'(acc); rdy = push_rdy;
      step();
      if (rdy) acc++;
    end
    push = 0;
    chk("load_accepted", acc, 24);
    repeat (40) step();
    chk("full_count", count, 8); chk("full_req", sp_req, 0); chk("full_ovf", ovf, 0); chk("full_tos", tos, 16'h0117);
    push = 1; din = 16'hFFFF; step(); push = 0;
    chk("ovf_set", ovf, 1); chk("ovf_count", count, 8); chk("ovf_tos", tos, 16'h0117);
    clr_err = 1; step(); clr_err = 0;
    chk("ovf_clr", ovf, 0);
    e = 23;
    for (int c = 0; c < 600 && e >= 0; c++) begin
      if (pop_rdy) begin
        chk($sformatf("drain_tos%0d", e), tos, 16'h0100 + 16'(e));
        pop = 1; e--;
      end else pop = 0;
      step();
    end
    pop = 0;
    chk("drain_done", e, -1);
    repeat (4) step();
    chk("drain_count", count, 0); chk("drain_unf", unf, 0);
    pop = 1; step(); pop = 0;
    chk("drain_unf_set", unf, 1);
    // reset while a spill is outstanding
    auto_m = 0; sp_ack = 0;
    reset = 1; step(); reset = 0;
    for (int k = 0; k < 6; k++) begin
      push = 1; din = 16'hC000 + 16'(k); step();
    end
    push = 0;
    for (int c = 0; c < 10 && !sp_req; c++) step();
    chk("abort_req_before", sp_req, 1);
    reset = 1; push = 1; sp_ack = 1; step();
    reset = 0; push = 0; sp_ack = 0;
    chk("abort_req", sp_req, 0); chk("abort_count", count, 0); chk("abort_tos", tos, 0);
    chk("abort_we", sp_we, 0); chk("abort_addr", sp_addr, 0); chk("abort_wdata", sp_wdata, 0);
    pop = 1; step(); pop = 0;
    chk("abort_bdepth_unf", unf, 1); chk("abort_count2", count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
